imem_responder: RTL and testbench
=================================

IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 SHALL provide parameter DEPTH, default 256, number of 32-bit instruction words stored.
REQ-002 SHALL provide parameter WAIT_CYCLES, default 2, wait states between request accept and response (range 0..15).
REQ-003 SHALL provide parameter NOP_INSTR, default 32'h00000013, instruction returned on error and at reset.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port areset  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid  input  1  fetch request from PC side.
REQ-007 SHALL have port req_ready  output  1  responder can accept a request.
REQ-008 SHALL have port req_addr  input  32  byte address of the instruction.
REQ-009 SHALL have port rsp_valid  output  1  response available.
REQ-010 SHALL have port rsp_ready  input  1  consumer accepts the response.
REQ-011 SHALL have port rsp_instr  output  32  fetched instruction word.
REQ-012 SHALL have port rsp_addr  output  32  byte address the response belongs to.
REQ-013 SHALL have port rsp_err  output  1  out-of-range (or misaligned, see Configuration) access.
REQ-014 SHALL have port prog_we  input  1  program-load write enable.
REQ-015 SHALL have port prog_addr  input  32  program-load byte address (word index = prog_addr[31:2]).
REQ-016 SHALL have port prog_data  input  32  program-load write data.
REQ-017 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-018 SHALL implement FSM states IDLE, WAIT, RESP; one request in flight at most.
REQ-019 IDLE: req_ready=1; on req_valid&req_ready, SHALL capture req_addr and load counter with WAIT_CYCLES; go to WAIT if WAIT_CYCLES>0, else RESP.
REQ-020 WAIT: req_ready=0; counter decrements each cycle; on the cycle counter equals 1, go to RESP.
REQ-021 On entry to RESP, SHALL register rsp_instr, rsp_addr, rsp_err; rsp_valid rises WAIT_CYCLES+1 edges after the accepting edge.
REQ-022 RESP: rsp_valid=1, req_ready=0; rsp_instr/rsp_addr/rsp_err SHALL remain stable until rsp_valid&rsp_ready, then go to IDLE, rsp_valid=0 next cycle.
REQ-023 No request is accepted in the cycle a response handshakes; back-to-back throughput is one fetch per WAIT_CYCLES+2 cycles.
REQ-024 Word index = addr[31:2]; index >= DEPTH SHALL give rsp_err=1, rsp_instr=NOP_INSTR.
REQ-025 prog_we SHALL write prog_data to word prog_addr[31:2] on the clock edge in any FSM state; index >= DEPTH writes ignored.
REQ-026 prog write to the same word on the edge the response is registered SHALL yield the old data; later fetches see the new data.
REQ-027 req_valid while req_ready=0 SHALL be ignored (not queued).

Reset
REQ-028 areset low SHALL asynchronously force IDLE, counter 0, rsp_valid 0, rsp_err 0, rsp_addr 0, rsp_instr NOP_INSTR, busy 0.
REQ-029 Reset mid-WAIT or mid-RESP SHALL abandon the in-flight request with no response issued.
REQ-030 Memory array contents SHALL NOT be reset.

Configuration
REQ-031 Macro IMEM_MISALIGN_CHECK_EN defined: addr[1:0]!=0 SHALL give rsp_err=1, rsp_instr=NOP_INSTR, with normal latency.
REQ-032 Macro undefined: addr[1:0] SHALL be ignored; rsp_err reflects range only.

Verification
REQ-033 Load word 1 = 32'h00500093, request addr 0x4 with WAIT_CYCLES=2 -> rsp_valid on 3rd edge after accept, rsp_instr=32'h00500093, rsp_addr=0x4, rsp_err=0.
REQ-034 Hold rsp_ready=0 for 5 cycles -> rsp_valid/rsp_instr stable, req_ready=0; req_valid with addr 0x8 during this time ignored.
REQ-035 Request addr 0x400 with DEPTH=256 -> rsp_err=1, rsp_instr=32'h00000013.
REQ-036 Request addr 0x6 -> macro defined: rsp_err=1, NOP_INSTR; undefined: rsp_err=0, word 1 data.
REQ-037 Drop areset during WAIT -> rsp_valid=0, busy=0, req_ready=1 immediately; no response after release.
REQ-038 WAIT_CYCLES=0 with rsp_ready=1 held, back-to-back requests 0x0, 0x4 -> responses 2 cycles apart, in order.

Source files
------------

// File: rtl/imem_responder.sv
// Instruction-fetch responder: one request in flight, fixed wait states, program-load write port.
// Define IMEM_MISALIGN_CHECK_EN to also flag addresses with addr[1:0] != 0 as errors.
module imem_responder #(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] NOP_INSTR   = 32'h00000013
) (
    input  logic        clk,
    input  logic        areset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_instr,
    output logic [31:0] rsp_addr,
    output logic        rsp_err,
    input  logic        prog_we,
    input  logic [31:0] prog_addr,
    input  logic [31:0] prog_data,
    output logic        busy
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StWait = 2'd1;
    localparam logic [1:0] StResp = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] rsp_instr_q, rsp_instr_d;
    logic [31:0] rsp_addr_q, rsp_addr_d;
    logic        rsp_err_q, rsp_err_d;

    logic [31:0] mem [DEPTH];

    logic [31:0] rd_addr;
    logic [29:0] rd_idx;
    logic        rd_oor;
    logic        rd_err;
    logic [31:0] rd_data;
    logic        load_rsp;
    logic        prog_hit;
    logic        unused_prog_lsb;

    // With zero wait states the response is built straight from the incoming address.
    assign rd_addr = (state_q == StIdle) ? req_addr : addr_q;
    assign rd_idx  = rd_addr[31:2];
    assign rd_oor  = {2'b00, rd_idx} >= DEPTH;
    assign rd_data = mem[rd_idx[AW-1:0]];

`ifdef IMEM_MISALIGN_CHECK_EN
    assign rd_err = rd_oor || (rd_addr[1:0] != 2'b00);
`else
    assign rd_err = rd_oor;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        rsp_instr_d = rsp_instr_q;
        rsp_addr_d  = rsp_addr_q;
        rsp_err_d   = rsp_err_q;
        load_rsp    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    addr_d = req_addr;
                    cnt_d  = 4'(WAIT_CYCLES);
                    if (WAIT_CYCLES == 0) begin
                        state_d  = StResp;
                        load_rsp = 1'b1;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d  = StResp;
                    load_rsp = 1'b1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // Read happens before this edge's program write lands, so a colliding write is not seen.
        if (load_rsp) begin
            rsp_instr_d = rd_err ? NOP_INSTR : rd_data;
            rsp_addr_d  = rd_addr;
            rsp_err_d   = rd_err;
        end
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            addr_q      <= 32'd0;
            rsp_instr_q <= NOP_INSTR;
            rsp_addr_q  <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            rsp_instr_q <= rsp_instr_d;
            rsp_addr_q  <= rsp_addr_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign prog_hit        = prog_we && ({2'b00, prog_addr[31:2]} < DEPTH);
    assign unused_prog_lsb = ^prog_addr[1:0];

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (prog_hit) begin
            mem[prog_addr[AW+1:2]] <= prog_data;
        end
    end

    assign req_ready = (state_q == StIdle);
    assign rsp_valid = (state_q == StResp);
    assign busy      = (state_q != StIdle);
    assign rsp_instr = rsp_instr_q;
    assign rsp_addr  = rsp_addr_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_imem_responder.sv
// Randomized scoreboard bench for imem_responder: instance 0 uses 2 wait states, instance 1 none.
// A timed memory model resolves each expected response on the edge the DUT should register it.
module tb_imem_responder;

    localparam int unsigned DEPTH = 256;
    localparam logic [31:0] NOP   = 32'h00000013;
    localparam int          W0    = 2;
    localparam int          W1    = 0;
`ifdef IMEM_MISALIGN_CHECK_EN
    localparam bit MISALIGN = 1'b1;
`else
    localparam bit MISALIGN = 1'b0;
`endif

    typedef struct {
        int          inst;
        logic [31:0] addr;
        logic [31:0] instr;
        logic        err;
        int          due;
        bit          seen;
    } exp_t;

    logic        clk;
    logic        areset;
    logic        req_valid [2];
    logic        req_ready [2];
    logic [31:0] req_addr  [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_instr [2];
    logic [31:0] rsp_addr  [2];
    logic        rsp_err   [2];
    logic        busy      [2];
    logic        prog_we;
    logic [31:0] prog_addr;
    logic [31:0] prog_data;

    exp_t        q[$];
    logic [31:0] mem_m [DEPTH];
    int          cyc       = 0;
    int          checks    = 0;
    int          errors    = 0;
    int          hs_count  = 0;
    int          hs_cyc    = 0;
    int          hs_prev   = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        imem_responder #(
            .DEPTH      (DEPTH),
            .WAIT_CYCLES((g == 0) ? W0 : W1),
            .NOP_INSTR  (NOP)
        ) u_dut (
            .clk      (clk),
            .areset   (areset),
            .req_valid(req_valid[g]),
            .req_ready(req_ready[g]),
            .req_addr (req_addr[g]),
            .rsp_valid(rsp_valid[g]),
            .rsp_ready(rsp_ready[g]),
            .rsp_instr(rsp_instr[g]),
            .rsp_addr (rsp_addr[g]),
            .rsp_err  (rsp_err[g]),
            .prog_we  (prog_we),
            .prog_addr(prog_addr),
            .prog_data(prog_data),
            .busy     (busy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wc(input int i);
        return (i == 0) ? W0 : W1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: memory with edge-timed writes; responses resolved on their due edge.
    initial begin : resolver
        exp_t        e;
        int unsigned idx;
        forever begin
            @(posedge clk);
            for (int k = 0; k < q.size(); k++) begin
                if (q[k].due == cyc + 1) begin
                    e       = q[k];
                    idx     = e.addr >> 2;
                    e.err   = (idx >= DEPTH) || (MISALIGN && (e.addr[1:0] != 2'b00));
                    e.instr = e.err ? NOP : mem_m[idx];
                    q[k]    = e;
                end
            end
            if (prog_we && ((prog_addr >> 2) < DEPTH)) mem_m[prog_addr >> 2] = prog_data;
            cyc++;
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (areset) begin
                for (int i = 0; i < 2; i++) begin
                    if (rsp_valid[i]) begin
                        if (q.size() == 0 || q[0].inst != i) begin
                            checks++;
                            errors++;
                            $display("FAIL spurious_rsp inst%0d: got rsp_valid=1 addr %h expected no response",
                                     i, rsp_addr[i]);
                        end else begin
                            e = q[0];
                            if (!e.seen) begin
                                chk($sformatf("latency%0d", i), 32'(cyc), 32'(e.due));
                                e.seen = 1'b1;
                                q[0]   = e;
                            end
                            chk($sformatf("rsp_instr%0d", i), rsp_instr[i], e.instr);
                            chk($sformatf("rsp_addr%0d", i), rsp_addr[i], e.addr);
                            chk($sformatf("rsp_err%0d", i), 32'(rsp_err[i]), 32'(e.err));
                            chk($sformatf("req_ready_resp%0d", i), 32'(req_ready[i]), 32'd0);
                            chk($sformatf("busy_resp%0d", i), 32'(busy[i]), 32'd1);
                            if (rsp_ready[i]) begin
                                hs_prev = hs_cyc;
                                hs_cyc  = cyc + 1;
                                hs_count++;
                                void'(q.pop_front());
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic check_idle(input int i, input string tag);
        chk($sformatf("%s_rsp_valid%0d", tag, i), 32'(rsp_valid[i]), 32'd0);
        chk($sformatf("%s_busy%0d", tag, i), 32'(busy[i]), 32'd0);
        chk($sformatf("%s_req_ready%0d", tag, i), 32'(req_ready[i]), 32'd1);
        chk($sformatf("%s_rsp_instr%0d", tag, i), rsp_instr[i], NOP);
        chk($sformatf("%s_rsp_addr%0d", tag, i), rsp_addr[i], 32'd0);
        chk($sformatf("%s_rsp_err%0d", tag, i), 32'(rsp_err[i]), 32'd0);
    endtask

    // Called at posedge+1 with the DUT idle.
    task automatic issue(input int i, input logic [31:0] a);
        exp_t e;
        chk($sformatf("req_ready_idle%0d", i), 32'(req_ready[i]), 32'd1);
        req_valid[i] = 1'b1;
        req_addr[i]  = a;
        e.inst  = i;
        e.addr  = a;
        e.instr = '0;
        e.err   = 1'b0;
        e.due   = cyc + 1 + wc(i);
        e.seen  = 1'b0;
        q.push_back(e);
    endtask

    // hold: loop iterations with rsp_ready=0 and a stray req to 0x8; rdy1 forces rsp_ready=1.
    task automatic wait_rsp(input int i, input int hold, input bit rdy1, input bit clash);
        int start;
        bit done;
        start = hs_count;
        done  = 1'b0;
        for (int k = 0; k < 60 && !done; k++) begin
            @(posedge clk);
            #1;
            if (hs_count != start) begin
                done = 1'b1;
            end else begin
                if (k < hold) begin
                    rsp_ready[i] = 1'b0;
                    req_valid[i] = 1'b1;
                end else begin
                    rsp_ready[i] = rdy1 ? 1'b1 : 1'($urandom_range(0, 1));
                    req_valid[i] = 1'($urandom_range(0, 1));
                end
                req_addr[i] = 32'h8;
                prog_we     = ($urandom_range(0, 3) == 0);
                prog_addr   = (32'($urandom_range(0, 299)) << 2) | 32'($urandom_range(0, 3));
                prog_data   = $urandom;
                if (clash && q.size() > 0 && q[0].due == cyc + 1) begin
                    prog_we   = 1'b1;
                    prog_addr = {q[0].addr[31:2], 2'b00};
                end
            end
        end
        req_valid[i] = 1'b0;
        rsp_ready[i] = 1'b0;
        prog_we      = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL timeout inst%0d: got no handshake in 60 cycles, expected a response", i);
            q.delete();
        end
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 99);
        if (r < 70) return 32'($urandom_range(0, DEPTH - 1)) << 2;
        else if (r < 80) return 32'($urandom_range(DEPTH, 4000)) << 2;
        else if (r < 85) return 32'hFFFF_FFFC;
        else return (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        areset    = 1'b0;
        prog_we   = 1'b0;
        prog_addr = '0;
        prog_data = '0;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0;
            req_addr[i]  = '0;
            rsp_ready[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) check_idle(i, "reset");
        areset = 1'b1;

        for (int w = 0; w < DEPTH; w++) begin
            @(posedge clk);
            #1;
            prog_we   = 1'b1;
            prog_addr = 32'(w) << 2;
            prog_data = (w == 1) ? 32'h00500093 : $urandom;
        end
        @(posedge clk);
        #1;
        prog_we = 1'b0;

        // Basic fetch, then a stalled consumer with a stray request to 0x8.
        issue(0, 32'h4);
        wait_rsp(0, 0, 1'b1, 1'b0);
        issue(0, 32'h4);
        wait_rsp(0, W0 + 5, 1'b0, 1'b0);
        issue(0, 32'h400);
        wait_rsp(0, 0, 1'b0, 1'b0);
        issue(0, 32'h6);
        wait_rsp(0, 0, 1'b0, 1'b0);
        // Write to the fetched word on the response edge: old data expected, new data afterwards.
        issue(0, 32'h8);
        wait_rsp(0, 0, 1'b0, 1'b1);
        issue(0, 32'h8);
        wait_rsp(0, 0, 1'b0, 1'b0);

        // Reset while waiting: in-flight request is dropped.
        issue(0, 32'h10);
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        areset       = 1'b0;
        #1;
        q.delete();
        check_idle(0, "midreset");
        @(posedge clk);
        #1;
        areset       = 1'b1;
        rsp_ready[0] = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        rsp_ready[0] = 1'b0;

        for (int n = 0; n < 40; n++) begin
            issue(0, rand_addr());
            wait_rsp(0, 0, 1'b0, 1'($urandom_range(0, 1)));
        end

        // Zero wait states, consumer always ready: back-to-back responses two cycles apart.
        issue(1, 32'h0);
        wait_rsp(1, 0, 1'b1, 1'b0);
        issue(1, 32'h4);
        wait_rsp(1, 0, 1'b1, 1'b0);
        chk("b2b_gap", 32'(hs_cyc - hs_prev), 32'd2);

        for (int n = 0; n < 20; n++) begin
            issue(1, rand_addr());
            wait_rsp(1, 0, 1'b0, 1'b0);
        end

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
